// File: rtl/graphics_pkg.sv
// graphics_pkg: shared types for the block fill engine.
// Holds the fill-mode and FSM state enums plus small width helpers.
package graphics_pkg;

  typedef enum logic [1:0] {
    SOLID   = 2'd0,
    CHECKER = 2'd1,
    RECT    = 2'd2
  } fill_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Bit width needed to index n items, never less than one bit so that
  // a degenerate 1-wide grid still yields a legal vector.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Mode code 3 is reserved and behaves as a solid fill.
  function automatic fill_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return CHECKER;
      2'd2:    return RECT;
      default: return SOLID;
    endcase
  endfunction

endpackage

// File: rtl/block_color_sel.sv
// block_color_sel: combinational colour choice for one grid cell, given the
// latched fill mode, the current block column/row and the latched operands.
module block_color_sel
  import graphics_pkg::*;
#(
  parameter int XW      = 6,
  parameter int YW      = 6,
  parameter int COLOR_W = 8
) (
  input  fill_mode_e         mode_i,
  input  logic [XW-1:0]      bx_i,
  input  logic [YW-1:0]      by_i,
  input  logic [XW-1:0]      x0_i,
  input  logic [XW-1:0]      x1_i,
  input  logic [YW-1:0]      y0_i,
  input  logic [YW-1:0]      y1_i,
  input  logic [COLOR_W-1:0] color_a_i,
  input  logic [COLOR_W-1:0] color_b_i,
  output logic [COLOR_W-1:0] color_o
);

  logic in_rect;

  // An inverted bound (x0 > x1 or y0 > y1) makes the window empty on its own,
  // so every cell falls outside and takes color_b.
  assign in_rect = (bx_i >= x0_i) && (bx_i <= x1_i) &&
                   (by_i >= y0_i) && (by_i <= y1_i);

  // Pick primary or secondary colour for the current cell.
  always_comb begin
    color_o = color_a_i;
    case (mode_i)
      CHECKER: if (bx_i[0] ^ by_i[0]) color_o = color_b_i;
      RECT:    if (!in_rect)          color_o = color_b_i;
      default: color_o = color_a_i;
    endcase
  end

endmodule

// File: rtl/block_fill_engine.sv
// block_fill_engine: sweeps every block of a GRID_W x GRID_H grid in raster
// order and issues one framebuffer write per block with a colour chosen by
// solid / checker / rectangle fill rules.
// Optional macro BLOCK_FILL_ABORT_EN enables the abort input; without it the
// abort port is present but ignored.
//
// Write handshake: wr_en is the valid, wr_ready the ready. A write transfers
// on a cycle where both are 1. While wr_en=1 and wr_ready=0, addr_write and
// color hold their values until the transfer happens.
module block_fill_engine
  import graphics_pkg::*;
#(
  parameter int  H_RES      = 640,
  parameter int  V_RES      = 480,
  parameter int  BLOCK_SIZE = 10,
  parameter int  COLOR_W    = 8,
  localparam int GRID_W     = H_RES / BLOCK_SIZE,
  localparam int GRID_H     = V_RES / BLOCK_SIZE,
  localparam int XW         = clog2_min1(GRID_W),
  localparam int YW         = clog2_min1(GRID_H),
  localparam int ADDR_W     = clog2_min1(GRID_W * GRID_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] color_a,
  input  logic [COLOR_W-1:0] color_b,
  input  logic [XW-1:0]      rect_x0,
  input  logic [XW-1:0]      rect_x1,
  input  logic [YW-1:0]      rect_y0,
  input  logic [YW-1:0]      rect_y1,
  input  logic               abort,
  input  logic               wr_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  addr_write,
  output logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done
);

  fsm_state_e         state_q;
  logic [XW-1:0]      bx_q, bx_d;
  logic [YW-1:0]      by_q, by_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  fill_mode_e         mode_q;
  logic [COLOR_W-1:0] color_a_q, color_b_q;
  logic [XW-1:0]      x0_q, x1_q;
  logic [YW-1:0]      y0_q, y1_q;
  logic               last_col, last_row;
  logic               in_run;
  logic [COLOR_W-1:0] cell_color;

`ifndef BLOCK_FILL_ABORT_EN
  logic unused_abort;
  assign unused_abort = abort;
`endif

  // Raster-order cursor advance; the address is a running counter kept in
  // step with by*GRID_W+bx so no multiplier is needed and it never exceeds
  // GRID_W*GRID_H-1 while a write is presented.
  always_comb begin
    last_col = (bx_q == XW'(GRID_W - 1));
    last_row = (by_q == YW'(GRID_H - 1));
    bx_d     = last_col ? '0 : bx_q + XW'(1);
    by_d     = last_col ? by_q + YW'(1) : by_q;
    addr_d   = addr_q + ADDR_W'(1);
  end

  // Sweep FSM: latch operands on start, step on each accepted write, pulse DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bx_q      <= '0;
      by_q      <= '0;
      addr_q    <= '0;
      mode_q    <= SOLID;
      color_a_q <= '0;
      color_b_q <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q    <= decode_mode(mode);
            color_a_q <= color_a;
            color_b_q <= color_b;
            x0_q      <= rect_x0;
            x1_q      <= rect_x1;
            y0_q      <= rect_y0;
            y1_q      <= rect_y1;
            bx_q      <= '0;
            by_q      <= '0;
            addr_q    <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
`ifdef BLOCK_FILL_ABORT_EN
          // Abort wins over a simultaneous transfer: that write is not counted.
          if (abort) begin
            state_q <= DONE;
          end else
`endif
          if (wr_ready) begin
            if (last_col && last_row) begin
              state_q <= DONE;
              bx_q    <= '0;
              by_q    <= '0;
              addr_q  <= '0;
            end else begin
              bx_q   <= bx_d;
              by_q   <= by_d;
              addr_q <= addr_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          bx_q    <= '0;
          by_q    <= '0;
          addr_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  block_color_sel #(
    .XW      (XW),
    .YW      (YW),
    .COLOR_W (COLOR_W)
  ) u_color_sel (
    .mode_i    (mode_q),
    .bx_i      (bx_q),
    .by_i      (by_q),
    .x0_i      (x0_q),
    .x1_i      (x1_q),
    .y0_i      (y0_q),
    .y1_i      (y1_q),
    .color_a_i (color_a_q),
    .color_b_i (color_b_q),
    .color_o   (cell_color)
  );

  // Outputs decode registered state only; write data is forced to zero
  // whenever no write is being presented.
  assign in_run     = (state_q == RUN);
  assign wr_en      = in_run;
  assign busy       = in_run;
  assign done       = (state_q == DONE);
  assign addr_write = in_run ? addr_q : '0;
  assign color      = in_run ? cell_color : '0;

endmodule

// File: tb/tb_block_fill_engine.sv
// tb_block_fill_engine: directed bench for block_fill_engine on a 4x3 grid
// (H_RES=40, V_RES=30, BLOCK_SIZE=10). Inputs change and outputs are sampled
// on the falling clock edge.
module tb_block_fill_engine;

  localparam int H_RES      = 40;
  localparam int V_RES      = 30;
  localparam int BLOCK_SIZE = 10;
  localparam int COLOR_W    = 8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [7:0] color_a, color_b;
  logic [1:0] rect_x0, rect_x1;
  logic [1:0] rect_y0, rect_y1;
  logic       abort;
  logic       wr_ready;
  logic       wr_en;
  logic [3:0] addr_write;
  logic [7:0] color;
  logic       busy;
  logic       done;

  int         n_checks;
  int         n_fail;
  logic [7:0] exp_q[$];
  int         exp_addr;

  block_fill_engine #(
    .H_RES      (H_RES),
    .V_RES      (V_RES),
    .BLOCK_SIZE (BLOCK_SIZE),
    .COLOR_W    (COLOR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .color_a    (color_a),
    .color_b    (color_b),
    .rect_x0    (rect_x0),
    .rect_x1    (rect_x1),
    .rect_y0    (rect_y0),
    .rect_y1    (rect_y1),
    .abort      (abort),
    .wr_ready   (wr_ready),
    .wr_en      (wr_en),
    .addr_write (addr_write),
    .color      (color),
    .busy       (busy),
    .done       (done)
  );

  // Clock and counters
  initial begin
    clk      = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    exp_addr = 0;
  end
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_row(input logic [7:0] c0, input logic [7:0] c1,
                          input logic [7:0] c2, input logic [7:0] c3);
    exp_q.push_back(c0);
    exp_q.push_back(c1);
    exp_q.push_back(c2);
    exp_q.push_back(c3);
  endtask

  task automatic push_all(input logic [7:0] c);
    for (int r = 0; r < 3; r++) push_row(c, c, c, c);
  endtask

  // Pulse start for one cycle, then scramble every operand so a sweep that
  // failed to latch its inputs would show wrong colours.
  task automatic do_start(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] x0, input logic [1:0] x1,
                          input logic [1:0] y0, input logic [1:0] y1);
    mode    = m;
    color_a = a;
    color_b = b;
    rect_x0 = x0;
    rect_x1 = x1;
    rect_y0 = y0;
    rect_y1 = y1;
    start   = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    mode     = m ^ 2'b01;
    color_a  = ~a;
    color_b  = ~b;
    rect_x0  = ~x0;
    rect_x1  = ~x1;
    rect_y0  = ~y0;
    rect_y1  = ~y1;
    exp_addr = 0;
  endtask

  // Expect n consecutive accepted writes with wr_ready held high.
  task automatic expect_writes(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      chk("wr_en", wr_en, 1);
      chk("busy", busy, 1);
      chk("addr", addr_write, exp_addr);
      chk("color", color, e);
      exp_addr++;
      @(negedge clk);
    end
  endtask

  // Cycle after the last accepted write: one done pulse, then idle.
  task automatic check_done();
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_wr_en", wr_en, 0);
    chk("done_addr", addr_write, 0);
    chk("done_color", color, 0);
    chk("writes_left", exp_q.size(), 0);
    @(negedge clk);
    chk("done_low", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_wr_en", wr_en, 0);
  endtask

  // Directed sequence
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 2'd0;
    color_a  = 8'h00;
    color_b  = 8'h00;
    rect_x0  = 2'd0;
    rect_x1  = 2'd0;
    rect_y0  = 2'd0;
    rect_y1  = 2'd0;
    abort    = 1'b0;
    wr_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", addr_write, 0);
    chk("rst_color", color, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_wr_en", wr_en, 0);

    // Solid F0, start re-asserted mid-sweep must be ignored
    push_all(8'hF0);
    do_start(2'd0, 8'hF0, 8'h0F, 2'd0, 2'd0, 2'd0, 2'd0);
    start = 1'b1;
    expect_writes(4);
    start = 1'b0;
    expect_writes(8);
    check_done();

    // Checker FF/00
    push_row(8'hFF, 8'h00, 8'hFF, 8'h00);
    push_row(8'h00, 8'hFF, 8'h00, 8'hFF);
    push_row(8'hFF, 8'h00, 8'hFF, 8'h00);
    do_start(2'd1, 8'hFF, 8'h00, 2'd0, 2'd0, 2'd0, 2'd0);
    expect_writes(12);
    check_done();

    // Rectangle x 1..2, y 1..1
    push_row(8'h03, 8'h03, 8'h03, 8'h03);
    push_row(8'h03, 8'h1C, 8'h1C, 8'h03);
    push_row(8'h03, 8'h03, 8'h03, 8'h03);
    do_start(2'd2, 8'h1C, 8'h03, 2'd1, 2'd2, 2'd1, 2'd1);
    expect_writes(12);
    check_done();

    // Rectangle with x0 > x1: every cell gets color_b
    push_all(8'h55);
    do_start(2'd2, 8'hAA, 8'h55, 2'd2, 2'd1, 2'd0, 2'd2);
    expect_writes(12);
    check_done();

    // Rectangle with y0 > y1: every cell gets color_b
    push_all(8'h66);
    do_start(2'd2, 8'h99, 8'h66, 2'd0, 2'd3, 2'd2, 2'd1);
    expect_writes(12);
    check_done();

    // Reserved mode 3 behaves as solid
    push_all(8'h3C);
    do_start(2'd3, 8'h3C, 8'hC3, 2'd0, 2'd0, 2'd0, 2'd0);
    expect_writes(12);
    check_done();

    // Back-pressure on sweep cycles 3..5 (checker 81/7E)
    push_row(8'h81, 8'h7E, 8'h81, 8'h7E);
    push_row(8'h7E, 8'h81, 8'h7E, 8'h81);
    push_row(8'h81, 8'h7E, 8'h81, 8'h7E);
    do_start(2'd1, 8'h81, 8'h7E, 2'd0, 2'd0, 2'd0, 2'd0);
    expect_writes(3);
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_wr_en", wr_en, 1);
      chk("stall_addr", addr_write, 3);
      chk("stall_color", color, 8'h7E);
      @(negedge clk);
    end
    wr_ready = 1'b1;
    expect_writes(9);
    check_done();

    // Reset mid-sweep at address 6: outputs clear, no done pulse
    push_all(8'h99);
    do_start(2'd0, 8'h99, 8'h11, 2'd0, 2'd0, 2'd0, 2'd0);
    expect_writes(6);
    chk("pre_rst_addr", addr_write, 6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_addr", addr_write, 0);
    chk("mid_rst_color", color, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end

    // Operands were cleared by reset: solid sweep with new values still works
    push_all(8'h42);
    do_start(2'd0, 8'h42, 8'h24, 2'd0, 2'd0, 2'd0, 2'd0);
    expect_writes(12);
    check_done();

    // Abort at address 6
    push_all(8'h77);
    do_start(2'd0, 8'h77, 8'h88, 2'd0, 2'd0, 2'd0, 2'd0);
    expect_writes(6);
    abort = 1'b1;
`ifdef BLOCK_FILL_ABORT_EN
    @(negedge clk);
    abort = 1'b0;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 1);
    chk("abort_addr", addr_write, 0);
    @(negedge clk);
    chk("abort_done_low", done, 0);
    chk("abort_idle", wr_en, 0);
    exp_q.delete();
`else
    // Abort is ignored: the sweep runs to completion
    expect_writes(6);
    abort = 1'b0;
    check_done();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/block_fill_engine.md
BLOCK_FILL_ENGINE -- requirements
Module: block_fill_engine

Interface
REQ-001 Parameter H_RES, default 640, horizontal pixel resolution.
REQ-002 Parameter V_RES, default 480, vertical pixel resolution.
REQ-003 Parameter BLOCK_SIZE, default 10, pixels per block edge; GRID_W=H_RES/BLOCK_SIZE, GRID_H=V_RES/BLOCK_SIZE (integer division, remainder pixels ignored).
REQ-004 Parameter COLOR_W, default 8, colour word width; ADDR_W=$clog2(GRID_W*GRID_H) derived.
REQ-005 Clocking SHALL be one clock `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-006 Ports SHALL be:
  - clk  in  1  system clock
  - rst  in  1  sync active-high reset
  - start  in  1  begin sweep (sampled in IDLE only)
  - mode  in  2  0=solid, 1=checker, 2=rect, 3=reserved (treated as solid)
  - color_a  in  COLOR_W  primary colour
  - color_b  in  COLOR_W  secondary colour
  - rect_x0, rect_x1  in  $clog2(GRID_W)  inclusive block-column bounds
  - rect_y0, rect_y1  in  $clog2(GRID_H)  inclusive block-row bounds
  - abort  in  1  stop sweep (see Configuration)
  - wr_ready  in  1  framebuffer accepts write
  - wr_en  out  1  write valid
  - addr_write  out  ADDR_W  block address = by*GRID_W+bx
  - color  out  COLOR_W  write data
  - busy  out  1  high in RUN
  - done  out  1  one-cycle completion pulse

Function
REQ-007 FSM states SHALL be IDLE, RUN, DONE.
REQ-008 IDLE with start=1 SHALL latch mode, colours and rect bounds, clear bx/by, and enter RUN next cycle.
REQ-009 Start SHALL be ignored outside IDLE; inputs changing mid-sweep SHALL have no effect.
REQ-010 In RUN, wr_en SHALL be 1; a write is accepted on a cycle with wr_en=1 and wr_ready=1.
REQ-011 While wr_ready=0, addr_write and color SHALL hold stable.
REQ-012 On acceptance, bx SHALL increment; at bx=GRID_W-1 it SHALL wrap to 0 and by SHALL increment.
REQ-013 The acceptance at bx=GRID_W-1, by=GRID_H-1 SHALL move to DONE; DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-014 Colour SHALL be: solid -> color_a; checker -> color_a if (bx^by)[0]==0, else color_b; rect -> color_a if x0<=bx<=x1 and y0<=by<=y1, else color_b.
REQ-015 In rect mode with x0>x1 or y0>y1, every cell SHALL receive color_b.
REQ-016 Address arithmetic SHALL be computed at ADDR_W bits with no overflow for any legal parameter set.
REQ-017 Exactly GRID_W*GRID_H writes SHALL be accepted per completed sweep; first address 0, last GRID_W*GRID_H-1.
REQ-018 Outside RUN, wr_en=0, addr_write=0 and color=0.

Reset
REQ-019 rst=1 SHALL force IDLE, bx=by=0, wr_en=0, addr_write=0, color=0, busy=0, done=0, and clear latched operands, within the same clock edge.
REQ-020 Reset asserted mid-sweep SHALL abandon the sweep without a done pulse.

Configuration
REQ-021 Macro BLOCK_FILL_ABORT_EN defined: abort=1 in RUN SHALL drop wr_en and enter DONE next cycle (done pulses once); the write in flight on that cycle SHALL NOT count as accepted.
REQ-022 Macro undefined: the abort port SHALL exist but SHALL be ignored.

Structure
REQ-023 Package graphics_pkg SHALL hold the fill_mode_e enum (SOLID, CHECKER, RECT) and the fsm state enum.
REQ-024 Sub-module block_color_sel (combinational colour selection from mode, bx, by, latched operands) SHALL be instantiated once.

Verification
REQ-025 Bench uses H_RES=40, V_RES=30, BLOCK_SIZE=10 (4x3 grid, 12 cells).
REQ-026 Solid, color_a=8'hF0, wr_ready=1 -> 12 writes, addr 0..11 on consecutive cycles, all 8'hF0, done one cycle after addr 11.
REQ-027 Checker, a=8'hFF, b=8'h00 -> addr 0=FF, 1=00, 4=00, 5=FF, 11=00.
REQ-028 Rect x0=1,x1=2,y0=1,y1=1, a=8'h1C, b=8'h03 -> addr 5,6 = 1C; all other 10 addresses = 03.
REQ-029 wr_ready low cycles 3-5 of sweep -> addr/color stable throughout, still exactly 12 accepted writes, no duplicates.
REQ-030 rst pulsed at addr 6 -> outputs zero next cycle, no done; with BLOCK_FILL_ABORT_EN, abort at addr 6 -> wr_en=0 next cycle, done pulses once, 6 writes accepted.
